// File: rtl/secuenciador_venta.sv
// Vending sequencer: accumulates coin credit, checks it against the price,
// then strobes dispense and returns change one unit per cycle.
module secuenciador_venta #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int TIMER_W     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       moneda_valida,
  input  logic [3:0] moneda_valor,
  input  logic       avance,
  input  logic       cancelar,
  input  logic [3:0] precio,
  output logic [3:0] estado_actual,
  output logic [3:0] credito,
  output logic       hay_credito,
  output logic       dispensar,
  output logic       devolver,
  output logic       rechazo,
  output logic       ocupado
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ACUMULA = 4'd1,
    VALIDA  = 4'd2,
    ENTREGA = 4'd3,
    CAMBIO  = 4'd4,
    ERROR   = 4'd5
  } estado_t;

  estado_t              estado_q, estado_d;
  logic [3:0]           credito_q, credito_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 avance_q;
  logic                 rechazo_q, rechazo_d;

  logic                 avance_ev;
  logic [4:0]           suma;
  logic                 cabe;
  logic                 acepta;
  logic                 timeout;

  assign avance_ev = avance & ~avance_q;
  // 5-bit sum so a coin that would overflow the 4-bit credit is caught, not wrapped
  assign suma      = {1'b0, credito_q} + {1'b0, moneda_valor};
  assign cabe      = (suma <= 5'd15);
  assign timeout   = (timer_q == TIMER_W'(TIMEOUT_CYC - 1));

  always_comb begin
    estado_d  = estado_q;
    credito_d = credito_q;
    acepta    = 1'b0;
    case (estado_q)
      IDLE: begin
        if (moneda_valida && cabe) begin
          acepta   = 1'b1;
          estado_d = ACUMULA;
        end
      end
      ACUMULA: begin
        if (cancelar)                   estado_d = CAMBIO;
        else if (avance_ev)             estado_d = VALIDA;
        else if (moneda_valida && cabe) acepta   = 1'b1;
        else if (timeout)               estado_d = CAMBIO;
      end
      VALIDA: begin
        if (credito_q >= precio) begin
          credito_d = credito_q - precio;
          estado_d  = ENTREGA;
        end else begin
          estado_d  = ERROR;
        end
      end
      ENTREGA: estado_d = (credito_q == 4'd0) ? IDLE : CAMBIO;
      CAMBIO: begin
        if (credito_q != 4'd0) credito_d = credito_q - 4'd1;
        else                   estado_d  = IDLE;
      end
      ERROR: begin
        if (cancelar)       estado_d = CAMBIO;
        else if (avance_ev) estado_d = ACUMULA;
        else if (timeout)   estado_d = CAMBIO;
      end
      default: estado_d = IDLE;
    endcase

    if (acepta) credito_d = suma[3:0];
    rechazo_d = moneda_valida & ~acepta;

    // Inactivity timer only runs while waiting on the user
    if ((estado_d != estado_q) || acepta || avance_ev)
      timer_d = '0;
    else if ((estado_q == ACUMULA) || (estado_q == ERROR))
      timer_d = timer_q + 1'b1;
    else
      timer_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= IDLE;
      credito_q <= 4'd0;
      timer_q   <= '0;
      avance_q  <= 1'b0;
      rechazo_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      credito_q <= credito_d;
      timer_q   <= timer_d;
      avance_q  <= avance;
      rechazo_q <= rechazo_d;
    end
  end

  assign estado_actual = estado_q;
  assign credito       = credito_q;
  assign hay_credito   = (credito_q != 4'd0);
  assign dispensar     = (estado_q == ENTREGA);
  assign devolver      = (estado_q == CAMBIO) && (credito_q != 4'd0);
  assign rechazo       = rechazo_q;
  assign ocupado       = (estado_q == VALIDA) || (estado_q == ENTREGA) ||
                         (estado_q == CAMBIO);

endmodule

// File: tb/tb_secuenciador_venta.sv
// Directed bench for secuenciador_venta with a short timeout (8 cycles).
module tb_secuenciador_venta;

  logic       clk = 1'b0;
  logic       rst;
  logic       moneda_valida;
  logic [3:0] moneda_valor;
  logic       avance;
  logic       cancelar;
  logic [3:0] precio;
  logic [3:0] estado_actual;
  logic [3:0] credito;
  logic       hay_credito;
  logic       dispensar;
  logic       devolver;
  logic       rechazo;
  logic       ocupado;

  int n_checks = 0;
  int n_fail   = 0;
  int n_dev, n_disp, n_val;

  secuenciador_venta #(.TIMEOUT_CYC(8), .TIMER_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .moneda_valida (moneda_valida),
    .moneda_valor  (moneda_valor),
    .avance        (avance),
    .cancelar      (cancelar),
    .precio        (precio),
    .estado_actual (estado_actual),
    .credito       (credito),
    .hay_credito   (hay_credito),
    .dispensar     (dispensar),
    .devolver      (devolver),
    .rechazo       (rechazo),
    .ocupado       (ocupado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are stable 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input int v);
    moneda_valida = 1'b1;
    moneda_valor  = 4'(v);
    step();
    moneda_valida = 1'b0;
    moneda_valor  = 4'd0;
  endtask

  task automatic press();
    avance = 1'b1;
    step();
    avance = 1'b0;
  endtask

  // Run until IDLE, tallying devolver/dispensar samples on the way
  task automatic run_out(input int maxc, output int nd, output int np);
    nd = 0;
    np = 0;
    for (int i = 0; i < maxc && estado_actual != 4'd0; i++) begin
      nd += int'(devolver);
      np += int'(dispensar);
      step();
    end
    chk("run_out_idle", estado_actual, 0);
  endtask

  initial begin
    rst = 1'b1; moneda_valida = 1'b0; moneda_valor = 4'd0;
    avance = 1'b0; cancelar = 1'b0; precio = 4'd0;
    step(); step();
    chk("rst_estado", estado_actual, 0);
    chk("rst_credito", credito, 0);
    chk("rst_strobes", {hay_credito, dispensar, devolver, rechazo, ocupado}, 0);
    rst = 1'b0;

    // Reset while accumulating discards credit without change pulses
    coin(7);
    chk("acum_estado", estado_actual, 1);
    chk("acum_credito", credito, 7);
    chk("acum_hay_credito", hay_credito, 1);
    rst = 1'b1;
    step();
    chk("midrst_estado", estado_actual, 0);
    chk("midrst_credito", credito, 0);
    chk("midrst_devolver", devolver, 0);
    step();
    rst = 1'b0;
    chk("midrst_strobes", {hay_credito, dispensar, devolver, rechazo, ocupado}, 0);

    // Purchase with change: 5+5, price 7 -> 3 change units
    coin(5);
    coin(5);
    chk("buy_credito", credito, 10);
    chk("buy_ocupado_acum", ocupado, 0);
    precio = 4'd7;
    press();
    chk("buy_valida", estado_actual, 2);
    chk("buy_ocupado", ocupado, 1);
    step();
    chk("buy_entrega", estado_actual, 3);
    chk("buy_entrega_cred", credito, 3);
    chk("buy_dispensar", dispensar, 1);
    step();
    chk("buy_cambio", estado_actual, 4);
    chk("buy_disp_once", dispensar, 0);
    run_out(20, n_dev, n_disp);
    chk("buy_dev_pulses", n_dev, 3);
    chk("buy_credito_end", credito, 0);

    // Insufficient credit, then top up to the exact price
    coin(4);
    precio = 4'd9;
    press();
    step();
    chk("err_estado", estado_actual, 5);
    chk("err_credito", credito, 4);
    coin(1 + 14);  // rejected in ERROR
    chk("err_coin_rechazo", rechazo, 1);
    chk("err_coin_credito", credito, 4);
    press();
    chk("err_back_acum", estado_actual, 1);
    coin(5);
    chk("exact_credito", credito, 9);
    press();
    step();
    chk("exact_entrega", estado_actual, 3);
    chk("exact_credito0", credito, 0);
    run_out(20, n_dev, n_disp);
    chk("exact_dev_pulses", n_dev, 0);
    chk("exact_disp", n_disp, 1);

    // Overflow rejection, then coin pre-empted by avance
    coin(12);
    coin(5);
    chk("ovf_rechazo", rechazo, 1);
    chk("ovf_credito", credito, 12);
    step();
    chk("ovf_rechazo_clr", rechazo, 0);
    moneda_valida = 1'b1; moneda_valor = 4'd2; avance = 1'b1;
    step();
    moneda_valida = 1'b0; moneda_valor = 4'd0; avance = 1'b0;
    chk("prio_valida", estado_actual, 2);
    chk("prio_credito", credito, 12);
    chk("prio_rechazo", rechazo, 1);
    run_out(20, n_dev, n_disp);
    chk("prio_dev_pulses", n_dev, 3);

    // Zero-value coin is accepted and moves IDLE -> ACUMULA
    coin(0);
    chk("zero_estado", estado_actual, 1);
    chk("zero_rechazo", rechazo, 0);
    cancelar = 1'b1;
    step();
    cancelar = 1'b0;
    run_out(5, n_dev, n_disp);
    chk("zero_dev_pulses", n_dev, 0);

    // Inactivity timeout after 8 cycles in ACUMULA
    coin(3);
    for (int i = 0; i < 7; i++) step();
    chk("tmo_still_acum", estado_actual, 1);
    step();
    chk("tmo_cambio", estado_actual, 4);
    run_out(20, n_dev, n_disp);
    chk("tmo_dev_pulses", n_dev, 3);

    // Held button produces a single VALIDA entry
    coin(6);
    precio = 4'd0;
    avance = 1'b1;
    n_val  = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (estado_actual == 4'd2) n_val++;
    end
    avance = 1'b0;
    chk("hold_valida_entries", n_val, 1);
    step();
    chk("hold_idle", estado_actual, 0);

    // Cancel returns the full credit and never dispenses
    coin(6);
    cancelar = 1'b1;
    step();
    cancelar = 1'b0;
    chk("cancel_cambio", estado_actual, 4);
    run_out(20, n_dev, n_disp);
    chk("cancel_dev_pulses", n_dev, 6);
    chk("cancel_no_disp", n_disp, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
